stack_ctrl: RTL and testbench

- Controller and arbiter for the 32-entry hardware call/return stack memory (push on write, pop on read, one-cycle registered read data).
- Shares the stack between two requesters: req0 is the control unit (CALL/RET), req1 is the exception/interrupt unit (context save/restore).
- Sequences each push or pop through a small FSM. Guards against overflow and underflow so the stack memory never sees an illegal access. Reports occupancy and sticky error flags.

---
 rtl/stack_ctrl_if.sv | 26 ++
 rtl/stack_ctrl.sv | 149 ++++++++++++++
 tb/tb_stack_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Requester-side handshake bundle for stack_ctrl: two request/ack ports
// plus the shared pop data and error indication.
interface stack_ctrl_if #(
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          op0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic          op1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req0, op0, wdata0, req1, op1, wdata1,
    input  ack0, ack1, rdata, err
  );

  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1,
    output ack0, ack1, rdata, err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Two-requester arbiter and sequencer for the call/return stack memory,
// with overflow/underflow guarding, occupancy count and sticky error flags.
module stack_ctrl #(
  parameter int unsigned DEPTH = 31,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  stack_ctrl_if.slave   bus,
  output logic          stk_write,
  output logic          stk_read,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [5:0]    count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  input  logic          err_clr
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    POP_WAIT,
    ACK
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          op_q, op_d;
  logic          last_q, last_d;
  logic [5:0]    count_q, count_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ovf_set, unf_set;
  logic          g_sel, g_op;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    last_d  = last_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    // Round-robin only matters on a tie; a lone requester always wins.
    g_sel   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    g_op    = g_sel ? bus.op1 : bus.op0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d  = g_sel;
          last_d = g_sel;
          op_d   = g_op;
          if (!g_op) begin
            if (count_q == DEPTH_C) begin
              err_d   = 1'b1;
              ovf_set = 1'b1;
              state_d = ACK;
            end else begin
              state_d = PUSH;
            end
          end else begin
            if (count_q == '0) begin
              err_d   = 1'b1;
              unf_set = 1'b1;
              state_d = ACK;
            end else begin
              state_d = POP;
            end
          end
        end
      end
      PUSH: begin
        count_d = count_q + 6'd1;
        err_d   = 1'b0;
        state_d = ACK;
      end
      POP: begin
        count_d = count_q - 6'd1;
        state_d = POP_WAIT;
      end
      POP_WAIT: begin
        rdata_d = stk_dout;
        err_d   = 1'b0;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      last_q  <= last_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Strobes decode from the state register alone, so async reset kills them at once.
  assign stk_write = (state_q == PUSH);
  assign stk_read  = (state_q == POP);
  assign stk_din   = gnt_q ? bus.wdata1 : bus.wdata0;

  assign bus.ack0  = (state_q == ACK) && !gnt_q;
  assign bus.ack1  = (state_q == ACK) &&  gnt_q;
  assign bus.err   = (state_q == ACK) &&  err_q;
  assign bus.rdata = rdata_q;

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized self-checking bench for stack_ctrl against a queue-based
// reference of the stack, arbitration order and sticky flags.
module tb_stack_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stk_write;
  logic        stk_read;
  logic [31:0] stk_din;
  logic [31:0] stk_dout;
  logic [5:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;
  logic        err_clr;

  stack_ctrl_if #(.DW(32)) bus ();

  stack_ctrl #(.DEPTH(31), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .stk_write(stk_write),
    .stk_read (stk_read),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack memory: push on write, pop on read with one-cycle registered data.
  logic [31:0] mem [32];
  int          sp;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_write) begin
      if (sp < 32) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_read) begin
      if (sp > 0 && sp <= 32) stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  int          nwr = 0;
  int          nrd = 0;
  int          both_cnt = 0;
  logic [31:0] last_din;
  always @(negedge clk) begin
    if (stk_write) begin
      nwr      = nwr + 1;
      last_din = stk_din;
    end
    if (stk_read) nrd = nrd + 1;
    if (stk_write && stk_read) both_cnt = both_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model
  logic [31:0] q[$];
  bit          m_last;
  logic [31:0] m_rdata;
  bit          m_ovf;
  bit          m_unf;

  task automatic model_reset();
    q.delete();
    m_last  = 1'b1;
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic run_ops(input bit r0, input bit r1, input bit o0, input bit o1,
                         input logic [31:0] w0, input logic [31:0] w1);
    bit          p0, p1, g, op, first, e_err;
    int          lat, cyc, wr0, rd0;
    logic [31:0] data;
    @(negedge clk);
    bus.req0 = r0; bus.op0 = o0; bus.wdata0 = w0;
    bus.req1 = r1; bus.op1 = o1; bus.wdata1 = w1;
    p0 = r0; p1 = r1; first = 1'b1;
    while (p0 || p1) begin
      g      = (p0 && p1) ? ~m_last : p1;
      m_last = g;
      op     = g ? o1 : o0;
      data   = g ? w1 : w0;
      wr0    = nwr;
      rd0    = nrd;
      if (!op) begin
        if (q.size() == 31) begin e_err = 1; lat = 1; m_ovf = 1; end
        else begin e_err = 0; lat = 2; q.push_back(data); end
      end else begin
        if (q.size() == 0) begin e_err = 1; lat = 1; m_unf = 1; end
        else begin e_err = 0; lat = 3; m_rdata = q.pop_back(); end
      end
      if (!first) @(posedge clk);
      first = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!(bus.ack0 || bus.ack1) && cyc < 8);
      chk("ack_latency", cyc, lat);
      chk("ack0", bus.ack0, 32'(g == 1'b0));
      chk("ack1", bus.ack1, 32'(g == 1'b1));
      chk("err", bus.err, 32'(e_err));
      chk("rdata", bus.rdata, m_rdata);
      chk("count", count, q.size());
      chk("full", full, 32'(q.size() == 31));
      chk("empty", empty, 32'(q.size() == 0));
      chk("ovf", ovf, 32'(m_ovf));
      chk("unf", unf, 32'(m_unf));
      chk("write_strobes", nwr - wr0, 32'(!op && !e_err));
      chk("read_strobes", nrd - rd0, 32'(op && !e_err));
      if (!op && !e_err) chk("stk_din", last_din, data);
      if (g) begin bus.req1 = 1'b0; p1 = 1'b0; end
      else   begin bus.req0 = 1'b0; p0 = 1'b0; end
    end
    @(posedge clk);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("ovf_cleared", ovf, 32'(m_ovf));
    chk("unf_cleared", unf, 32'(m_unf));
  endtask

  initial begin
    reset_n = 1'b0;
    err_clr = 1'b0;
    bus.req0 = 1'b0; bus.op0 = 1'b0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.op1 = 1'b0; bus.wdata1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ack", {bus.ack0, bus.ack1, bus.err}, 0);
    chk("rst_flags", {ovf, unf}, 0);
    chk("rst_rdata", bus.rdata, 0);

    // Reset in the middle of a push
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = 1'b0; bus.wdata0 = 32'hDEAD_0001;
    @(posedge clk); #1;
    chk("push_strobe_pre_rst", stk_write, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_strobe_drop", stk_write, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ack", {bus.ack0, bus.ack1}, 0);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Tie arbitration: grants alternate starting with requester 0
    run_ops(1, 1, 0, 0, 32'h10, 32'h20);
    run_ops(1, 1, 0, 0, 32'h10, 32'h20);
    repeat (4) run_ops(1, 0, 1, 0, '0, '0);

    // Ordering through requester 0
    run_ops(1, 0, 0, 0, 32'hA5A5_0001, '0);
    run_ops(1, 0, 0, 0, 32'hA5A5_0002, '0);
    run_ops(1, 0, 1, 0, '0, '0);
    run_ops(1, 0, 1, 0, '0, '0);

    // Underflow: rdata must hold the last popped value
    run_ops(1, 0, 1, 0, '0, '0);
    clear_flags();

    // Overflow
    for (int i = 0; i < 31; i++) run_ops(0, 1, 0, 0, '0, 32'h100 + 32'(i));
    run_ops(0, 1, 0, 0, '0, 32'hBAD0_0000);
    run_ops(1, 0, 0, 0, 32'hBAD0_0001, '0);
    clear_flags();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned pat;
      bit          ra, rb;
      pat = $urandom_range(1, 3);
      ra  = pat[0];
      rb  = pat[1];
      run_ops(ra, rb, 1'($urandom), 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 19) == 0) clear_flags();
    end
    while (q.size() > 0) run_ops(1, 0, 1, 0, '0, '0);
    run_ops(0, 1, 1, 1, '0, '0);

    chk("strobe_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
